// File: rtl/divider_restoring_nbit_if.sv
// Operand/result bundle between a controller (master) and the restoring divider (slave).
// No latency of its own: wires only.
// Flow control: start is accepted only while busy is low; done is a one-cycle pulse.
interface divider_restoring_nbit_if #(
    parameter int n = 16
) ();
    logic         start;
    logic [n-1:0] dividend;
    logic [n-1:0] divisor;
    logic [n-1:0] quotient;
    logic [n-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/divider_restoring_nbit.sv
// Combinational n-bit adder/subtractor: add_n=1 gives a - b, with c_out=1 meaning no borrow.
// Latency: purely combinational.
// No flow control.
module adder_subtractor_nbit #(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         add_n,
    output logic [n-1:0] sum,
    output logic         c_out,
    output logic         overflow
);
    logic [n-1:0] b_eff;

    assign b_eff          = b ^ {n{add_n}};
    assign {c_out, sum}   = {1'b0, a} + {1'b0, b_eff} + {{n{1'b0}}, add_n};
    assign overflow       = (a[n-1] == b_eff[n-1]) && (sum[n-1] != a[n-1]);
endmodule

// Sequential unsigned restoring divider, one quotient bit per clock.
// Latency: n edges from the accept edge to the done cycle; zero divisor completes on the accept edge.
// Backpressure: start is ignored while busy; a start in the done cycle begins the next division.
module divider_restoring_nbit #(
    parameter int n = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    divider_restoring_nbit_if.slave bus
);
    localparam int CW = $clog2(n) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [n-1:0]  a_q;
    logic [n-1:0]  b_q;
    logic [n:0]    p_q;
    logic [CW-1:0] cnt_q;
    logic [n-1:0]  quotient_q;
    logic [n-1:0]  remainder_q;
    logic          div_by_zero_q;

    logic          accept;
    logic          zero_div;
    logic          last_iter;
    logic [n:0]    pt;
    logic [n:0]    diff;
    logic          no_borrow;
    logic [n-1:0]  a_nxt;
    logic [n:0]    p_nxt;
    logic          sub_ovf_unused;
    logic          p_msb_unused;

    assign accept    = (state != RUN) && bus.start;
    assign zero_div  = (bus.divisor == '0);
    assign last_iter = (cnt_q == CW'(1));

    // Partial remainder after shift; its top bit is always 0 once the trial subtraction has restored.
    assign pt           = {p_q[n-1:0], a_q[n-1]};
    assign p_msb_unused = p_q[n];

    adder_subtractor_nbit #(
        .n (n + 1)
    ) u_trial_sub (
        .a        (pt),
        .b        ({1'b0, b_q}),
        .add_n    (1'b1),
        .sum      (diff),
        .c_out    (no_borrow),
        .overflow (sub_ovf_unused)
    );

    assign a_nxt = {a_q[n-2:0], no_borrow};
    assign p_nxt = no_borrow ? diff : pt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FIN: begin
                if (bus.start) begin
                    state_nxt = zero_div ? FIN : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_nxt = FIN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q           <= '0;
            b_q           <= '0;
            p_q           <= '0;
            cnt_q         <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else if (accept) begin
            a_q <= bus.dividend;
            b_q <= bus.divisor;
            p_q <= '0;
            if (zero_div) begin
                cnt_q         <= '0;
                quotient_q    <= '1;
                remainder_q   <= bus.dividend;
                div_by_zero_q <= 1'b1;
            end else begin
                cnt_q <= CW'(n);
            end
        end else if (state == RUN) begin
            a_q   <= a_nxt;
            p_q   <= p_nxt;
            cnt_q <= cnt_q - CW'(1);
            if (last_iter) begin
                quotient_q    <= a_nxt;
                remainder_q   <= p_nxt[n-1:0];
                div_by_zero_q <= 1'b0;
            end
        end
    end

    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == FIN);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;
endmodule

// File: tb/tb_divider_restoring_nbit.sv
// Bench for the restoring divider: directed vector table, handshake corner cases, random sweep vs q=x/y, r=x%y.
module tb_divider_restoring_nbit;
    localparam int N = 16;

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_bad;

    divider_restoring_nbit_if #(.n(N)) bus ();

    divider_restoring_nbit #(.n(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         z;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns just after the accept edge with start dropped and operands scrambled.
    task automatic launch(input logic [N-1:0] x, input logic [N-1:0] y);
        bus.dividend = x;
        bus.divisor  = y;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = N'($urandom);
        bus.divisor  = N'($urandom);
    endtask

    // lat counts edges after the accept edge before done is seen (n for normal, 0 for zero divisor).
    task automatic wait_done(output int lat, output int bcnt);
        int ovl  = 0;
        bit seen = 1'b0;
        lat  = 0;
        bcnt = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.busy && bus.done) ovl++;
            if (bus.busy) bcnt++;
            if (bus.done) seen = 1'b1;
            else lat++;
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("busy_done_overlap", 64'(ovl), 64'd0);
    endtask

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return N'($urandom_range(1, 15));
            default: return N'($urandom);
        endcase
    endfunction

    initial begin
        int lat;
        int bcnt;
        int dcnt;
        logic [N-1:0] x, y, eq, er;
        logic ez;

        n_vec = 0;
        n_bad = 0;

        tbl[0] = '{x: 16'd100,   y: 16'd7,      q: 16'd14,     r: 16'd2,     z: 1'b0};
        tbl[1] = '{x: 16'hFFFF,  y: 16'd1,      q: 16'hFFFF,   r: 16'd0,     z: 1'b0};
        tbl[2] = '{x: 16'd5,     y: 16'd9,      q: 16'd0,      r: 16'd5,     z: 1'b0};
        tbl[3] = '{x: 16'd1234,  y: 16'd0,      q: 16'hFFFF,   r: 16'd1234,  z: 1'b1};
        tbl[4] = '{x: 16'd50000, y: 16'd123,    q: 16'd406,    r: 16'd62,    z: 1'b0};
        tbl[5] = '{x: 16'd0,     y: 16'd5,      q: 16'd0,      r: 16'd0,     z: 1'b0};
        tbl[6] = '{x: 16'hFFFF,  y: 16'hFFFF,   q: 16'd1,      r: 16'd0,     z: 1'b0};
        tbl[7] = '{x: 16'd1,     y: 16'hFFFF,   q: 16'd0,      r: 16'd1,     z: 1'b0};
        tbl[8] = '{x: 16'd0,     y: 16'd0,      q: 16'hFFFF,   r: 16'd0,     z: 1'b1};

        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        repeat (2) @(negedge clk);
        chk("reset_quotient",    64'(bus.quotient),    64'd0);
        chk("reset_remainder",   64'(bus.remainder),   64'd0);
        chk("reset_busy",        64'(bus.busy),        64'd0);
        chk("reset_done",        64'(bus.done),        64'd0);
        chk("reset_div_by_zero", 64'(bus.div_by_zero), 64'd0);
        reset_n = 1'b1;

        foreach (tbl[k]) begin
            @(negedge clk);
            launch(tbl[k].x, tbl[k].y);
            wait_done(lat, bcnt);
            chk($sformatf("tbl%0d_result", k), {bus.quotient, bus.remainder, bus.div_by_zero},
                {tbl[k].q, tbl[k].r, tbl[k].z});
            chk($sformatf("tbl%0d_latency", k), 64'(lat), tbl[k].z ? 64'd0 : 64'd16);
            chk($sformatf("tbl%0d_busy_cycles", k), 64'(bcnt), tbl[k].z ? 64'd0 : 64'd16);
            @(negedge clk);
            chk($sformatf("tbl%0d_done_drop", k), 64'(bus.done), 64'd0);
            chk($sformatf("tbl%0d_hold", k), {bus.quotient, bus.remainder}, {tbl[k].q, tbl[k].r});
        end

        // Start pulsed mid-RUN must be ignored; a start in the done cycle runs back-to-back.
        @(negedge clk);
        launch(16'd1000, 16'd10);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 5) begin
                bus.start    = 1'b1;
                bus.dividend = 16'd9;
                bus.divisor  = 16'd3;
            end else if (i == 6) begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        chk("b2b_first_latency", 64'(lat), 64'd16);
        chk("b2b_first_result", {bus.quotient, bus.remainder}, {16'd100, 16'd0});
        launch(16'd9, 16'd3);
        wait_done(lat, bcnt);
        chk("b2b_second_latency", 64'(lat), 64'd16);
        chk("b2b_second_result", {bus.quotient, bus.remainder, bus.div_by_zero}, {16'd3, 16'd0, 1'b0});

        // Reset in the middle of a division aborts it with no completion.
        @(negedge clk);
        launch(16'd50000, 16'd123);
        repeat (8) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_quotient",    64'(bus.quotient),    64'd0);
        chk("abort_remainder",   64'(bus.remainder),   64'd0);
        chk("abort_busy",        64'(bus.busy),        64'd0);
        chk("abort_done",        64'(bus.done),        64'd0);
        chk("abort_div_by_zero", 64'(bus.div_by_zero), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        dcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        chk("abort_no_done", 64'(dcnt), 64'd0);
        launch(16'd50000, 16'd123);
        wait_done(lat, bcnt);
        chk("abort_rerun_result", {bus.quotient, bus.remainder}, {16'd406, 16'd62});

        // Random sweep, back-to-back in the done cycle.
        @(negedge clk);
        for (int i = 0; i < 2000; i++) begin
            x = pick();
            y = pick();
            if (y == 0) begin
                eq = '1;
                er = x;
                ez = 1'b1;
            end else begin
                eq = x / y;
                er = x % y;
                ez = 1'b0;
            end
            launch(x, y);
            wait_done(lat, bcnt);
            chk($sformatf("rand %0d/%0d", x, y), {bus.quotient, bus.remainder, bus.div_by_zero},
                {eq, er, ez});
            chk($sformatf("rand_latency %0d/%0d", x, y), 64'(lat), ez ? 64'd0 : 64'd16);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
